// File: rtl/ct_lsu_spsram_52_ctrl_pkg.sv
// Shared constants for the 512x52 LSU SRAM access controller: default geometry,
// the sweep state encoding and the per-cycle SRAM access kind.
package ct_lsu_spsram_52_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 9;
    localparam int unsigned DATA_WIDTH_DEF = 52;
    localparam int unsigned DEPTH_DEF      = 512;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_INIT = 1'b1;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_INIT = 2'd1,
        ACC_WR   = 2'd2,
        ACC_RD   = 2'd3
    } acc_e;

endpackage

// File: rtl/ct_lsu_spsram_52_ctrl_if.sv
// Request/response and SRAM pin bundle of the LSU SRAM controller.
// slave = the controller, master = requesters plus the SRAM macro.
interface ct_lsu_spsram_52_ctrl_if
    import ct_lsu_spsram_52_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  init_req;
    logic                  init_busy;
    logic                  wr_vld;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [DATA_WIDTH-1:0] wr_din;
    logic [DATA_WIDTH-1:0] wr_bit_mask;
    logic                  wr_grnt;
    logic                  rd_vld;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  rd_grnt;
    logic                  rd_data_vld;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] sram_a;
    logic                  sram_cen;
    logic                  sram_gwen;
    logic [DATA_WIDTH-1:0] sram_wen;
    logic [DATA_WIDTH-1:0] sram_d;
    logic [DATA_WIDTH-1:0] sram_q;

    modport slave (
        input  init_req, wr_vld, wr_idx, wr_din, wr_bit_mask, rd_vld, rd_idx, sram_q,
        output init_busy, wr_grnt, rd_grnt, rd_data_vld, rd_data,
               sram_a, sram_cen, sram_gwen, sram_wen, sram_d
    );

    modport master (
        output init_req, wr_vld, wr_idx, wr_din, wr_bit_mask, rd_vld, rd_idx, sram_q,
        input  init_busy, wr_grnt, rd_grnt, rd_data_vld, rd_data,
               sram_a, sram_cen, sram_gwen, sram_wen, sram_d
    );

endinterface

// File: rtl/ct_lsu_spsram_52_ctrl_init_cnt.sv
// Invalidate-sweep sequencer: owns the IDLE/INIT state, the entry counter and
// init_busy. One sweep write is issued per cycle while sweep_issue is high.
module ct_lsu_spsram_init_cnt
    import ct_lsu_spsram_52_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_req,
    output logic                  init_busy,
    output logic                  sweep_issue,
    output logic [ADDR_WIDTH-1:0] sweep_idx
);

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  done;
    logic                  cnt_last;

    assign cnt_last  = (cnt == CNT_LAST);
    assign init_busy = (state == ST_INIT);
    assign sweep_idx = cnt;

    // A request from IDLE issues entry 0 in the same cycle; once the last entry
    // is issued, INIT lingers one extra cycle (done) before dropping to IDLE.
    assign sweep_issue = (state == ST_INIT) ? !done : init_req;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state <= ST_INIT;
            cnt   <= '0;
            done  <= 1'b0;
        end else if (sweep_issue) begin
            state <= ST_INIT;
            if (cnt_last) begin
                done <= 1'b1;
            end else begin
                cnt <= cnt + ADDR_WIDTH'(1);
            end
        end else if (state == ST_INIT) begin
            state <= ST_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end
    end

endmodule

// File: rtl/ct_lsu_spsram_52_ctrl.sv
// LSU single-port SRAM access controller: invalidate sweep, write/read
// arbitration (init > write > read), registered SRAM pins and read-valid pipe.
module ct_lsu_spsram_52_ctrl
    import ct_lsu_spsram_52_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    ct_lsu_spsram_52_ctrl_if.slave  bus
);

    logic                  init_busy;
    logic                  sweep_issue;
    logic [ADDR_WIDTH-1:0] sweep_idx;
    logic                  grant_ok;
    logic                  wr_grnt;
    logic                  rd_grnt;
    acc_e                  acc;

    logic [ADDR_WIDTH-1:0] sram_a_p0;
    logic                  sram_cen_p0;
    logic                  sram_gwen_p0;
    logic [DATA_WIDTH-1:0] sram_wen_p0;
    logic [DATA_WIDTH-1:0] sram_d_p0;
    logic                  vld_p0;
    logic                  vld_p1;

    ct_lsu_spsram_init_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_init_cnt (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .init_req       (bus.init_req),
        .init_busy      (init_busy),
        .sweep_issue    (sweep_issue),
        .sweep_idx      (sweep_idx)
    );

    // An init_req seen in IDLE takes the port this cycle, so it blocks grants too.
    assign grant_ok = !init_busy && !bus.init_req;
    assign wr_grnt  = grant_ok && bus.wr_vld;
    assign rd_grnt  = grant_ok && !bus.wr_vld && bus.rd_vld;

    always_comb begin
        acc = ACC_NONE;
        if (sweep_issue) begin
            acc = ACC_INIT;
        end else if (wr_grnt && (|bus.wr_bit_mask)) begin
            acc = ACC_WR;
        end else if (rd_grnt) begin
            acc = ACC_RD;
        end
    end

    // ---- p0: SRAM pin registers (address/data hold when there is no access) ----
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sram_a_p0    <= '0;
            sram_cen_p0  <= 1'b1;
            sram_gwen_p0 <= 1'b1;
            sram_wen_p0  <= '1;
            sram_d_p0    <= '0;
        end else begin
            sram_cen_p0  <= 1'b1;
            sram_gwen_p0 <= 1'b1;
            sram_wen_p0  <= '1;
            case (acc)
                ACC_INIT: begin
                    sram_a_p0    <= sweep_idx;
                    sram_d_p0    <= '0;
                    sram_wen_p0  <= '0;
                    sram_gwen_p0 <= 1'b0;
                    sram_cen_p0  <= 1'b0;
                end
                ACC_WR: begin
                    sram_a_p0    <= bus.wr_idx;
                    sram_d_p0    <= bus.wr_din;
                    sram_wen_p0  <= ~bus.wr_bit_mask;
                    sram_gwen_p0 <= 1'b0;
                    sram_cen_p0  <= 1'b0;
                end
                ACC_RD: begin
                    sram_a_p0   <= bus.rd_idx;
                    sram_cen_p0 <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // ---- p0/p1: read-valid pipe (access cycle, then data cycle) ----
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= rd_grnt;
            vld_p1 <= vld_p0;
        end
    end

    assign bus.init_busy   = init_busy;
    assign bus.wr_grnt     = wr_grnt;
    assign bus.rd_grnt     = rd_grnt;
    assign bus.rd_data_vld = vld_p1;
    assign bus.rd_data     = bus.sram_q;
    assign bus.sram_a      = sram_a_p0;
    assign bus.sram_cen    = sram_cen_p0;
    assign bus.sram_gwen   = sram_gwen_p0;
    assign bus.sram_wen    = sram_wen_p0;
    assign bus.sram_d      = sram_d_p0;

endmodule
